segment_constraint: RTL and testbench

- Enforces the rest-length distance constraint between two adjacent rope nodes. It is the stage directly upstream of each node's fix-constraint inputs.
- The controller presents the current positions of node A and node B, pulses `start`, and after a fixed latency receives corrected positions. The controller then drives those onto the nodes' `x_fix_constraint`/`y_fix_constraint` during the fix-constraint phase.
- Multi-cycle: one 64-bit square-sum, a 32-iteration bit-serial square root, a 32-iteration restoring divide, then a single apply step.

---
 rtl/segment_constraint.sv | 166 ++++++++++++++++
 tb/tb_segment_constraint.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/segment_constraint.sv
// Rope segment distance constraint: pulls or pushes two nodes toward
// the rest length using a serial sqrt and a serial divide.
module segment_constraint #(
    parameter logic [31:0] REST  = 32'h01400000,
    parameter bit          PIN_A = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ax,
    input  logic [31:0] ay,
    input  logic [31:0] bx,
    input  logic [31:0] by,
    output logic        busy,
    output logic        done,
    output logic [31:0] ax_out,
    output logic [31:0] ay_out,
    output logic [31:0] bx_out,
    output logic [31:0] by_out
);

    typedef enum logic [2:0] {IDLE, SQUARE, SQRT, DIV, APPLY} state_t;

    state_t state, state_n;

    logic [4:0]  cnt;
    logic [31:0] pax, pay, pbx, pby, dx, dy;
    logic [63:0] rad;
    logic [35:0] rem;
    logic [31:0] root, divisor, div_rem, div_q;
    logic        neg, zero, sat;

    logic signed [63:0] sq_sum;
    logic [35:0] rem_sh, trial, rem_nxt;
    logic        sq_ge;
    logic [31:0] root_nxt;
    logic [32:0] diff, absd;
    logic        neg_c, zero_c, sat_c;
    logic [63:0] numer;
    logic [32:0] dv_sh, dv_sub;
    logic        dv_ge;
    logic [31:0] ratio;
    logic signed [63:0] prod_x, prod_y;
    logic [31:0] cx, cy, hx, hy;
    logic        unused_bits;

    assign busy = (state != IDLE);

    assign sq_sum = $signed(dx) * $signed(dx) + $signed(dy) * $signed(dy);

    // Bit-serial root: two radicand bits enter the remainder per step
    assign rem_sh   = {rem[33:0], rad[63:62]};
    assign trial    = {2'b00, root, 2'b01};
    assign sq_ge    = (rem_sh >= trial);
    assign rem_nxt  = sq_ge ? rem_sh - trial : rem_sh;
    assign root_nxt = {root[30:0], sq_ge};

    assign diff   = {1'b0, root_nxt} - {1'b0, REST};
    assign neg_c  = diff[32];
    assign absd   = neg_c ? -diff : diff;
    assign zero_c = (root_nxt == 32'd0);
    assign sat_c  = ({10'd0, absd} >= {1'b0, root_nxt, 10'd0});
    assign numer  = {10'd0, absd, 21'd0};

    // Saturation check guarantees the high dividend word is below divisor
    assign dv_sh  = {div_rem, div_q[31]};
    assign dv_ge  = (dv_sh >= {1'b0, divisor});
    assign dv_sub = dv_sh - {1'b0, divisor};

    always_comb begin
        ratio = neg ? -div_q : div_q;
        if (zero)
            ratio = 32'd0;
        else if (sat)
            ratio = neg ? 32'h80000001 : 32'h7FFFFFFF;
    end

    assign prod_x = $signed(dx) * $signed(ratio);
    assign prod_y = $signed(dy) * $signed(ratio);
    assign cx = prod_x[52:21];
    assign cy = prod_y[52:21];
    assign hx = {cx[31], cx[31:1]};
    assign hy = {cy[31], cy[31:1]};

    assign unused_bits = ^{prod_x[63:53], prod_x[20:0],
                           prod_y[63:53], prod_y[20:0], dv_sub[32]};

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = SQUARE;
            SQUARE:  state_n = SQRT;
            SQRT:    if (cnt == 5'd31) state_n = DIV;
            DIV:     if (cnt == 5'd31) state_n = APPLY;
            APPLY:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0; pax <= '0; pay <= '0; pbx <= '0; pby <= '0;
            dx <= '0; dy <= '0; rad <= '0; rem <= '0; root <= '0;
            divisor <= '0; div_rem <= '0; div_q <= '0;
            neg <= 1'b0; zero <= 1'b0; sat <= 1'b0; done <= 1'b0;
            ax_out <= '0; ay_out <= '0; bx_out <= '0; by_out <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    pax <= ax; pay <= ay; pbx <= bx; pby <= by;
                    dx  <= bx - ax;
                    dy  <= by - ay;
                end
                SQUARE: begin
                    rad  <= sq_sum;
                    rem  <= '0;
                    root <= '0;
                    cnt  <= '0;
                end
                SQRT: begin
                    rad  <= {rad[61:0], 2'b00};
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        divisor <= root_nxt;
                        neg     <= neg_c;
                        zero    <= zero_c;
                        sat     <= sat_c;
                        div_rem <= numer[63:32];
                        div_q   <= numer[31:0];
                    end
                end
                DIV: begin
                    div_rem <= dv_ge ? dv_sub[31:0] : dv_sh[31:0];
                    div_q   <= {div_q[30:0], dv_ge};
                    cnt     <= cnt + 5'd1;
                end
                APPLY: begin
                    done <= 1'b1;
                    if (PIN_A) begin
                        ax_out <= pax;
                        ay_out <= pay;
                        bx_out <= pbx - cx;
                        by_out <= pby - cy;
                    end else begin
                        ax_out <= pax + hx;
                        ay_out <= pay + hy;
                        bx_out <= pbx - hx;
                        by_out <= pby - hy;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_constraint.sv
// Scoreboard bench for segment_constraint: free and pinned-A instances,
// directed vectors, fixed-latency, ignored-start and mid-solve reset.
module tb_segment_constraint;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] ax = '0, ay = '0, bx = '0, by = '0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] ax0, ay0, bx0, by0, ax1, ay1, bx1, by1;

    segment_constraint #(.REST(32'h01400000), .PIN_A(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start0),
        .ax(ax), .ay(ay), .bx(bx), .by(by),
        .busy(busy0), .done(done0),
        .ax_out(ax0), .ay_out(ay0), .bx_out(bx0), .by_out(by0)
    );

    segment_constraint #(.REST(32'h01400000), .PIN_A(1'b1)) dut_p (
        .clk(clk), .reset(reset), .start(start1),
        .ax(ax), .ay(ay), .bx(bx), .by(by),
        .busy(busy1), .done(done1),
        .ax_out(ax1), .ay_out(ay1), .bx_out(bx1), .by_out(by1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] ax, ay, bx, by;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (!reset && done0) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut0 spurious done at cycle %0d", cyc);
            end else begin
                e = q0.pop_front();
                chk("dut0 ax_out", ax0, e.ax);
                chk("dut0 ay_out", ay0, e.ay);
                chk("dut0 bx_out", bx0, e.bx);
                chk("dut0 by_out", by0, e.by);
                chk("dut0 latency", cyc, e.cyc);
                chk("dut0 busy at done", {31'd0, busy0}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!reset && done1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut1 spurious done at cycle %0d", cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1 ax_out", ax1, e.ax);
                chk("dut1 ay_out", ay1, e.ay);
                chk("dut1 bx_out", bx1, e.bx);
                chk("dut1 by_out", by1, e.by);
                chk("dut1 latency", cyc, e.cyc);
                chk("dut1 busy at done", {31'd0, busy1}, 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle T+1
    task automatic issue(input bit p,
                         input logic [31:0] iax, iay, ibx, iby,
                         input logic [31:0] eax, eay, ebx, eby);
        exp_t e;
        ax = iax; ay = iay; bx = ibx; by = iby;
        e.ax = eax; e.ay = eay; e.bx = ebx; e.by = eby;
        e.cyc = cyc + 67;
        if (p) begin
            q1.push_back(e);
            start1 = 1'b1;
        end else begin
            q0.push_back(e);
            start0 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        chk(p ? "dut1 busy after start" : "dut0 busy after start",
            {31'd0, p ? busy1 : busy0}, 32'd1);
    endtask

    task automatic wait_done(input bit p);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = p ? done1 : done0;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done timeout dut%0d at cycle %0d", p, cyc);
        end
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done0) nd++;
        end
    endtask

    initial begin : guard
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int nd;
        repeat (3) @(negedge clk);
        chk("reset busy0", {31'd0, busy0}, 32'd0);
        chk("reset done0", {31'd0, done0}, 32'd0);
        chk("reset ax0", ax0, 32'd0);
        chk("reset bx0", bx0, 32'd0);
        chk("reset busy1", {31'd0, busy1}, 32'd0);
        chk("reset by1", by1, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // stretched: 20.0 -> each end moves 5.0
        issue(0, 32'h0, 32'h0, 32'h02800000, 32'h0,
                 32'h00A00000, 32'h0, 32'h01E00000, 32'h0);
        wait_done(0);
        @(negedge clk);
        // at rest (6,8): unchanged
        issue(0, 32'h0, 32'h0, 32'h00C00000, 32'h01000000,
                 32'h0, 32'h0, 32'h00C00000, 32'h01000000);
        wait_done(0);
        // back-to-back start in the done cycle; compressed (0,5)
        issue(0, 32'h0, 32'h0, 32'h0, 32'h00A00000,
                 32'h0, 32'hFFB00000, 32'h0, 32'h00F00000);
        wait_done(0);
        @(negedge clk);
        // coincident: dist 0, no correction
        issue(0, 32'h00200000, 32'h00200000, 32'h00200000, 32'h00200000,
                 32'h00200000, 32'h00200000, 32'h00200000, 32'h00200000);
        wait_done(0);
        @(negedge clk);
        // tiny dist: ratio saturates to -0x7FFFFFFF, cx = -1024
        issue(0, 32'h0, 32'h0, 32'h1, 32'h0,
                 32'hFFFFFE00, 32'h0, 32'h00000201, 32'h0);
        wait_done(0);

        // starts at T+5 and T+30 must be ignored
        @(negedge clk);
        issue(0, 32'h0, 32'h0, 32'h02800000, 32'h0,
                 32'h00A00000, 32'h0, 32'h01E00000, 32'h0);
        repeat (4) @(negedge clk);
        ax = 32'h12345678; by = 32'h0BADF00D;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (24) @(negedge clk);
        bx = 32'h7FFF0000;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0);
        count_done(75, nd);
        chk("ignored starts give one done", nd, 32'd0);

        // reset at T+20 aborts the solve
        @(negedge clk);
        issue(0, 32'h0, 32'h0, 32'h00C00000, 32'h01000000,
                 32'h0, 32'h0, 32'h00C00000, 32'h01000000);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q0.delete();
        chk("abort busy0", {31'd0, busy0}, 32'd0);
        chk("abort done0", {31'd0, done0}, 32'd0);
        chk("abort ax0", ax0, 32'd0);
        chk("abort ay0", ay0, 32'd0);
        chk("abort bx0", bx0, 32'd0);
        chk("abort by0", by0, 32'd0);
        count_done(80, nd);
        chk("no done after abort", nd, 32'd0);
        issue(0, 32'h0, 32'h0, 32'h0, 32'h00A00000,
                 32'h0, 32'hFFB00000, 32'h0, 32'h00F00000);
        wait_done(0);

        // pinned A: (3,4) -> B pushed out to (6,8)
        @(negedge clk);
        issue(1, 32'h0, 32'h0, 32'h00600000, 32'h00800000,
                 32'h0, 32'h0, 32'h00C00000, 32'h01000000);
        wait_done(1);

        @(negedge clk);
        chk("scoreboard drained", q0.size() + q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
